// File: rtl/v9_peak_sequencer.sv
// Peak sequencer: arms on a threshold crossing of the filter output, captures the
// window maximum and its timestamp, hands the record off, then enforces dead time.
module v9_peak_sequencer #(
  parameter int unsigned SIZE_ADC_DATA = 12,
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter int unsigned GATE_LEN      = 32,
  parameter int unsigned DEAD_LEN      = 16,
  parameter int unsigned TS_WIDTH      = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [SIZE_ADC_DATA-1:0] threshold,
  input  logic [SIZE_ADC_DATA-1:0] filt_data,
  output logic                     event_valid,
  input  logic                     event_ready,
  output logic [SIZE_ADC_DATA-1:0] event_peak,
  output logic [TS_WIDTH-1:0]      event_time,
  output logic                     event_pileup,
  output logic [7:0]               drop_cnt,
  output logic                     busy
);

  localparam int unsigned SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned WIN_W  = $clog2(GATE_LEN + 1);
  localparam int unsigned DEAD_W = $clog2(DEAD_LEN + 1);

  typedef enum logic [2:0] {
    ST_SETTLE,
    ST_IDLE,
    ST_ACQ,
    ST_OUT,
    ST_DEAD
  } state_t;

  state_t                   state, state_nxt;
  logic [SET_W-1:0]         settle_cnt, settle_cnt_nxt;
  logic [WIN_W-1:0]         win_cnt, win_cnt_nxt;
  logic [DEAD_W-1:0]        dead_cnt, dead_cnt_nxt;
  logic [TS_WIDTH-1:0]      ts;
  logic [SIZE_ADC_DATA-1:0] prev;
  logic [SIZE_ADC_DATA-1:0] peak, peak_nxt;
  logic [TS_WIDTH-1:0]      peak_time, peak_time_nxt;
  logic                     en_lost, en_lost_nxt;
  logic                     valid_nxt;
  logic [SIZE_ADC_DATA-1:0] ev_peak_nxt;
  logic [TS_WIDTH-1:0]      ev_time_nxt;
  logic                     pileup_nxt;
  logic [7:0]               drop_nxt;
  logic                     busy_nxt;
  logic                     crossing_c;
  logic                     new_max_c;

  assign crossing_c = (filt_data > threshold) && (prev <= threshold);
  assign new_max_c  = filt_data > peak;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_SETTLE;
    else        state <= state_nxt;
  end

  // Next-state and next-value logic
  always_comb begin
    state_nxt      = state;
    settle_cnt_nxt = settle_cnt;
    win_cnt_nxt    = win_cnt;
    dead_cnt_nxt   = dead_cnt;
    peak_nxt       = peak;
    peak_time_nxt  = peak_time;
    en_lost_nxt    = en_lost;
    valid_nxt      = event_valid;
    ev_peak_nxt    = event_peak;
    ev_time_nxt    = event_time;
    pileup_nxt     = event_pileup;
    drop_nxt       = drop_cnt;

    if (crossing_c && (state == ST_ACQ || state == ST_OUT || state == ST_DEAD) &&
        drop_cnt != 8'hFF)
      drop_nxt = drop_cnt + 8'd1;

    case (state)
      ST_SETTLE: begin
        if (!enable) begin
          settle_cnt_nxt = '0;
        end else if (settle_cnt == SET_W'(SETTLE_CYCLES - 1)) begin
          state_nxt      = ST_IDLE;
          settle_cnt_nxt = '0;
        end else begin
          settle_cnt_nxt = settle_cnt + SET_W'(1);
        end
      end
      ST_IDLE: begin
        if (!enable) begin
          state_nxt      = ST_SETTLE;
          settle_cnt_nxt = '0;
        end else if (crossing_c) begin
          state_nxt     = ST_ACQ;
          peak_nxt      = filt_data;
          peak_time_nxt = ts;
          win_cnt_nxt   = WIN_W'(1);
        end
      end
      ST_ACQ: begin
        if (!enable) begin
          state_nxt      = ST_SETTLE;
          settle_cnt_nxt = '0;
        end else begin
          if (new_max_c) begin
            peak_nxt      = filt_data;
            peak_time_nxt = ts;
          end
          if (win_cnt == WIN_W'(GATE_LEN - 1)) begin
            // Last window sample: publish the record including this sample
            state_nxt   = ST_OUT;
            valid_nxt   = 1'b1;
            ev_peak_nxt = new_max_c ? filt_data : peak;
            ev_time_nxt = new_max_c ? ts : peak_time;
            pileup_nxt  = filt_data > threshold;
            en_lost_nxt = 1'b0;
          end else begin
            win_cnt_nxt = win_cnt + WIN_W'(1);
          end
        end
      end
      ST_OUT: begin
        // Losing enable here is remembered so the handoff still completes
        if (!enable) en_lost_nxt = 1'b1;
        if (event_ready) begin
          valid_nxt = 1'b0;
          if (!enable || en_lost) begin
            state_nxt      = ST_SETTLE;
            settle_cnt_nxt = '0;
          end else begin
            state_nxt    = ST_DEAD;
            dead_cnt_nxt = '0;
          end
        end
      end
      ST_DEAD: begin
        if (!enable) begin
          state_nxt      = ST_SETTLE;
          settle_cnt_nxt = '0;
        end else if (dead_cnt != DEAD_W'(DEAD_LEN)) begin
          dead_cnt_nxt = dead_cnt + DEAD_W'(1);
        end else if (filt_data <= threshold) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt      = ST_SETTLE;
        settle_cnt_nxt = '0;
      end
    endcase

    busy_nxt = (state_nxt != ST_IDLE);
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      settle_cnt   <= '0;
      win_cnt      <= '0;
      dead_cnt     <= '0;
      ts           <= '0;
      prev         <= '0;
      peak         <= '0;
      peak_time    <= '0;
      en_lost      <= 1'b0;
      event_valid  <= 1'b0;
      event_peak   <= '0;
      event_time   <= '0;
      event_pileup <= 1'b0;
      drop_cnt     <= '0;
      busy         <= 1'b1;
    end else begin
      settle_cnt   <= settle_cnt_nxt;
      win_cnt      <= win_cnt_nxt;
      dead_cnt     <= dead_cnt_nxt;
      ts           <= ts + TS_WIDTH'(1);
      prev         <= filt_data;
      peak         <= peak_nxt;
      peak_time    <= peak_time_nxt;
      en_lost      <= en_lost_nxt;
      event_valid  <= valid_nxt;
      event_peak   <= ev_peak_nxt;
      event_time   <= ev_time_nxt;
      event_pileup <= pileup_nxt;
      drop_cnt     <= drop_nxt;
      busy         <= busy_nxt;
    end
  end

endmodule
